// File: rtl/burst_mem_responder_if.sv
// Bus bundle between a burst initiator (master) and a memory responder (slave).
//
// Handshake semantics: the initiator raises read_i or write_i with a line
// address and holds it high for the whole burst; there is no ready signal.
// The responder marks each of the four 64-bit beats with a single-cycle
// resp_o. Read data is valid on burst_o while resp_o is high. Write data must
// be on burst_i during every cycle resp_o is high and is taken at the edge
// ending that cycle. Dropping the request line mid-burst aborts the burst.
interface burst_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] address_i;
  logic              read_i;
  logic              write_i;
  logic [63:0]       burst_i;
  logic [63:0]       burst_o;
  logic              resp_o;

  modport master (
    output address_i, read_i, write_i, burst_i,
    input  burst_o, resp_o
  );

  modport slave (
    input  address_i, read_i, write_i, burst_i,
    output burst_o, resp_o
  );
endinterface

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat x 64-bit line burst protocol.
// Accepts a line-aligned read or write, waits LATENCY cycles, then streams or
// absorbs four beats against a small internal line store.
//
// Optional build macro BURST_MEM_STALL_EN: inserts one bubble cycle between
// beat 1 and beat 2 so initiators can be exercised against a stalled burst.
//
// state_dbg exposes the FSM state: 0 IDLE, 1 WAIT, 2 BEAT, 3 DONE.
module burst_mem_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 16,
  parameter int ADDR_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  burst_mem_responder_if.slave  bus,
  output logic [1:0]            state_dbg
);

  localparam int IDX_W = (DEPTH_LINES < 2) ? 1 : $clog2(DEPTH_LINES);
  localparam int LAT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [1:0]       beat_cnt;
  logic [IDX_W-1:0] idx;
  logic             op_write;
  logic             bubble;
  logic [63:0]      line_mem [DEPTH_LINES][4];

  // The latched op's own request line keeps the burst alive.
  logic req_live;
  // Index of an incoming request; only bits [5 +: IDX_W] select the line.
  logic [IDX_W-1:0] new_idx;
  // Address bits outside the index are deliberately ignored.
  logic unused_addr;

  // Decode request liveness and the incoming line index.
  always_comb begin
    req_live = op_write ? bus.write_i : bus.read_i;
    new_idx  = bus.address_i[5 +: IDX_W];
  end

  assign unused_addr = ^bus.address_i;
  assign state_dbg   = state;

  // Burst FSM with registered beat strobe, read data and line-store writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      beat_cnt    <= '0;
      idx         <= '0;
      op_write    <= 1'b0;
      bubble      <= 1'b0;
      bus.resp_o  <= 1'b0;
      bus.burst_o <= '0;
      for (int i = 0; i < DEPTH_LINES; i++) begin
        for (int j = 0; j < 4; j++) begin
          line_mem[i][j] <= '0;
        end
      end
    end else begin
      // Outputs are only non-zero during a beat; each branch re-arms them.
      bus.resp_o  <= 1'b0;
      bus.burst_o <= '0;
      case (state)
        IDLE: begin
          if (bus.write_i || bus.read_i) begin
            idx      <= new_idx;
            op_write <= bus.write_i;
            beat_cnt <= '0;
            bubble   <= 1'b0;
            lat_cnt  <= LAT_W'(LATENCY);
            if (LATENCY == 0) begin
              state      <= BEAT;
              bus.resp_o <= 1'b1;
              if (!bus.write_i) bus.burst_o <= line_mem[new_idx][0];
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (!req_live) begin
            state <= IDLE;
          end else if (lat_cnt <= LAT_W'(1)) begin
            lat_cnt    <= '0;
            state      <= BEAT;
            bus.resp_o <= 1'b1;
            if (!op_write) bus.burst_o <= line_mem[idx][0];
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end

        BEAT: begin
          if (!req_live) begin
            // Abort: the beat in flight is not committed.
            state  <= IDLE;
            bubble <= 1'b0;
          end else if (bubble) begin
            // Bubble cycle: nothing committed, resume with beat_cnt (beat 2).
            bubble     <= 1'b0;
            bus.resp_o <= 1'b1;
            if (!op_write) bus.burst_o <= line_mem[idx][beat_cnt];
          end else begin
            if (op_write) line_mem[idx][beat_cnt] <= bus.burst_i;
            if (beat_cnt == 2'd3) begin
              state <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 2'd1;
`ifdef BURST_MEM_STALL_EN
              if (beat_cnt == 2'd1) begin
                bubble <= 1'b1;
              end else begin
                bus.resp_o <= 1'b1;
                if (!op_write) bus.burst_o <= line_mem[idx][beat_cnt + 2'd1];
              end
`else
              bus.resp_o <= 1'b1;
              if (!op_write) bus.burst_o <= line_mem[idx][beat_cnt + 2'd1];
`endif
            end
          end
        end

        DONE: begin
          // Turnaround: both request lines must fall before a new request.
          if (!bus.read_i && !bus.write_i) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: a line-store model supplies the
// expected read beats, which are queued when a burst is driven and popped as
// resp_o strobes arrive.
module tb_burst_mem_responder;

`ifdef BURST_MEM_STALL_EN
  localparam int LAT   = 0;
  localparam int STALL = 1;
`else
  localparam int LAT   = 4;
  localparam int STALL = 0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd3;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;

  burst_mem_responder_if #(.ADDR_W(32)) bus ();

  burst_mem_responder #(
    .LATENCY     (LAT),
    .DEPTH_LINES (16),
    .ADDR_W      (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] model [16][4];
  logic [63:0] wbeats [4];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 4; j++)
        model[i][j] = '0;
  endtask

  task automatic set_beats(input logic [63:0] b0, b1, b2, b3);
    wbeats[0] = b0; wbeats[1] = b1; wbeats[2] = b2; wbeats[3] = b3;
  endtask

  function automatic int beat_cycle(input int k);
    return LAT + 1 + k + ((STALL != 0 && k >= 2) ? 1 : 0);
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; that cycle is T. abort_beat < 4 drops
  // the request lines during that beat.
  task automatic run_burst(input bit wr, input bit rd, input logic [31:0] addr,
                           input int abort_beat, input string tag);
    int  idx;
    int  nbeats;
    int  cyc;
    int  k;
    bit  done;
    logic [63:0] e;
    idx    = int'(addr[8:5]);
    nbeats = (abort_beat < 4) ? abort_beat + 1 : 4;
    for (int b = 0; b < nbeats; b++) begin
      if (wr) begin
        exp_q.push_back(64'h0);
        if (b < abort_beat) model[idx][b] = wbeats[b];
      end else begin
        exp_q.push_back(model[idx][b]);
      end
    end
    bus.address_i = addr;
    bus.write_i   = wr;
    bus.read_i    = rd;
    bus.burst_i   = $urandom;
    cyc  = 0;
    k    = 0;
    done = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) bus.address_i = $urandom;
      if (bus.resp_o) begin
        check({tag, "_beat_cycle"}, 64'(cyc), 64'(beat_cycle(k)));
        if (exp_q.size() == 0) begin
          check({tag, "_unexpected_beat"}, 64'(k), 64'(nbeats));
        end else begin
          e = exp_q.pop_front();
          check({tag, "_burst_o"}, bus.burst_o, e);
        end
        bus.burst_i = wbeats[k];
        if (k == abort_beat) begin
          bus.read_i  = 1'b0;
          bus.write_i = 1'b0;
          done = 1;
        end
        k++;
        if (k == 4) done = 1;
      end else begin
        check({tag, "_idle_burst_o"}, bus.burst_o, 64'h0);
      end
    end
    if (!done) check({tag, "_timeout"}, 64'(k), 64'(nbeats));
    @(posedge clk); #1;
    check({tag, "_resp_after"}, 64'(bus.resp_o), 64'h0);
    if (abort_beat < 4) begin
      check({tag, "_abort_idle"}, 64'(state_dbg), 64'(S_IDLE));
    end else begin
      check({tag, "_done_state"}, 64'(state_dbg), 64'(S_DONE));
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      @(posedge clk); #1;
      check({tag, "_back_idle"}, 64'(state_dbg), 64'(S_IDLE));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          k;
    int          cyc;
    logic [63:0] r;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    clear_model();
    set_beats('0, '0, '0, '0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_resp", 64'(bus.resp_o), 64'h0);
    check("reset_burst_o", bus.burst_o, 64'h0);
    check("reset_state", 64'(state_dbg), 64'(S_IDLE));
    reset = 1'b0;

    // Read latency from zeroed memory.
    run_burst(0, 1, 32'h40, 4, "rd40_zero");

    // Write then read back in order; other line untouched.
    set_beats(64'h1111111111111111, 64'h2222222222222222,
              64'h3333333333333333, 64'h4444444444444444);
    run_burst(1, 0, 32'h20, 4, "wr20");
    run_burst(0, 1, 32'h20, 4, "rd20");
    run_burst(0, 1, 32'h40, 4, "rd40_still_zero");

    // Simultaneous read and write: write wins.
    set_beats(64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5,
              64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5);
    run_burst(1, 1, 32'h60, 4, "rdwr60");
    run_burst(0, 1, 32'h60, 4, "rd60");

    // Upper address bits ignored: 0x200 aliases index 0; 0x1E0 is index 15.
    set_beats(64'hDEADDEADDEADDEAD, 64'hDEADBEEF00000001,
              64'hDEADBEEF00000002, 64'hDEADBEEF00000003);
    run_burst(1, 0, 32'h200, 4, "wr200");
    run_burst(0, 1, 32'h000, 4, "rd000_alias");
    set_beats({$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom});
    run_burst(1, 0, 32'h1E0, 4, "wr1E0");
    run_burst(0, 1, 32'hFFFF_FFE0, 4, "rd_idx15_alias");

    // Abort a read during beat 1.
    run_burst(0, 1, 32'h20, 1, "rd20_abort");
    run_burst(0, 1, 32'h20, 4, "rd20_after_abort");

    // Abort a write during beat 2: beats 0 and 1 stay committed.
    set_beats(64'h5555555555555555, 64'h6666666666666666,
              64'h7777777777777777, 64'h8888888888888888);
    run_burst(1, 0, 32'h20, 2, "wr20_abort");
    run_burst(0, 1, 32'h20, 4, "rd20_partial");

    // Reset in the middle of a write burst clears the whole store.
    bus.address_i = 32'h20;
    bus.write_i   = 1'b1;
    bus.burst_i   = 64'h9999999999999999;
    k   = 0;
    cyc = 0;
    while (k < 2 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.resp_o) k++;
    end
    check("rst_mid_beats_seen", 64'(k), 64'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_resp", 64'(bus.resp_o), 64'h0);
    check("rst_mid_state", 64'(state_dbg), 64'(S_IDLE));
    reset         = 1'b0;
    bus.write_i   = 1'b0;
    clear_model();
    @(posedge clk); #1;
    run_burst(0, 1, 32'h20, 4, "rd20_after_reset");
    run_burst(0, 1, 32'h60, 4, "rd60_after_reset");

    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    r = 64'(checks);
    $display("Simulation finished: %0d checks, %0d errors", r, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
